t1_event_builder: RTL and testbench
===================================

Name: t1_event_builder

Overview:
- Sits directly downstream of the trigger combiner and consumes its T1, T1 offset, matched L4 and L4-new outputs.
- Turns each T1 burst into one readout event record: start block address, length in blocks, L4 pattern, L4-new flags and a truncation flag.
- Queues records in a small FIFO for the IRS readout controller using a valid/ready handshake.
- Counts accepted and dropped events.

Parameters:
NUM_L4, 4, number of L4 trigger lines
BLOCK_BITS, 9, width of the IRS block address (512-block ring)
LEN_BITS, 8, width of the event length field
MAX_LEN, 255, length in blocks at which an event is forcibly closed
POST_BLOCKS, 4, blocks appended after T1 deasserts
FIFO_DEPTH_LOG2, 2, log2 of record FIFO depth (4 entries)

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, asynchronous, active-high
T1_i  in  1  masked T1 from the trigger combiner
T1_offset_i  in  9  blocks back from the current write block to the readout start
l4_i  in  NUM_L4  matched L4 triggers, aligned to T1_i
l4_new_i  in  NUM_L4  matched L4-new flags, aligned to T1_i
wr_block_i  in  BLOCK_BITS  IRS block currently being written
block_ce_i  in  1  one-cycle strobe; a block write has completed
ev_valid_o  out  1  FIFO head record valid
ev_ready_i  in  1  readout accepts the head record
ev_start_o  out  BLOCK_BITS  record start block
ev_len_o  out  LEN_BITS  record length in blocks
ev_pattern_o  out  NUM_L4  record OR of l4_i over the event
ev_new_o  out  NUM_L4  record OR of l4_new_i over the event
ev_trunc_o  out  1  record was closed by MAX_LEN
fifo_full_o  out  1  FIFO holds 2^FIFO_DEPTH_LOG2 records
event_count_o  out  16  records written; wraps
drop_count_o  out  16  records dropped because the FIFO was full; saturates at 0xFFFF

Behaviour:
- Reset: all outputs 0; FSM in IDLE; FIFO empty; counters 0. Reset asserted mid-event discards the event with no record and no count.
- FSM states: IDLE, ACTIVE, POST, PUSH.
- IDLE, T1_i=1:
  - Latch start = (wr_block_i - T1_offset_i[BLOCK_BITS-1:0]) mod 2^BLOCK_BITS, so 0 - 3 = 509.
  - Load pattern=l4_i, new=l4_new_i, len=1, trunc=0; go to ACTIVE.
- ACTIVE:
  - Every cycle with T1_i=1: pattern |= l4_i, new |= l4_new_i.
  - Each block_ce_i: len+1.
  - T1_i=0: load post_cnt=POST_BLOCKS and go to POST. If POST_BLOCKS=0, go straight to PUSH.
- POST:
  - T1_i=1: return to ACTIVE and OR in l4_i/l4_new_i (retrigger extends the same event; start is not re-latched).
  - Else each block_ce_i: len+1, post_cnt-1.
  - post_cnt reaching 0 goes to PUSH. A retrigger in the same cycle as expiry takes priority.
- MAX_LEN: in ACTIVE or POST, len reaching MAX_LEN sets trunc=1 and goes to PUSH next cycle, whatever T1_i is doing. len never exceeds MAX_LEN.
- PUSH (one cycle):
  - If the FIFO is not full (after this cycle's pop): write the record, event_count+1.
  - Else: discard the record, drop_count+1 (saturating).
  - If T1_i=1 in the PUSH cycle: start a new event exactly as from IDLE, going to ACTIVE. Otherwise go to IDLE.
- FIFO:
  - First-word-fall-through; head fields are stable while ev_valid_o=1 and ev_ready_i=0.
  - A pop occurs on ev_valid_o && ev_ready_i.
  - Simultaneous push and pop when full succeeds, because the pop frees the slot first.
  - A push into an empty FIFO shows ev_valid_o=1 on the cycle after the PUSH state.
  - Pointers wrap mod depth. fifo_full_o is registered.
- Latency:
  - The last T1_i high cycle reaches PUSH after POST_BLOCKS block_ce_i strobes plus 1 cycle.
  - The record is visible 1 cycle after PUSH.
- ev_ready_i while empty has no effect.

Test Plan:
- Single event: wr_block_i=100, T1_offset_i=6, T1_i high 3 cycles with l4_i=4'b0010 then 4'b0100, one block_ce_i during the high period, POST_BLOCKS=4 -> one record: start=94, len=6, pattern=4'b0110, trunc=0; event_count=1.
- Wrap-around: wr_block_i=2, T1_offset_i=5 -> ev_start_o=509.
- Retrigger: T1_i re-asserts after 2 of 4 post blocks -> single record with len covering both bursts plus 4 post blocks; event_count increments by 1.
- Truncation: T1_i held high for 300 block_ce_i strobes, MAX_LEN=255 -> record len=255, trunc=1. The still-high T1_i immediately starts a second event.
- Backpressure: ev_ready_i=0, 6 events generated -> 4 records queued, fifo_full_o=1, drop_count=2. Releasing ev_ready_i drains the records in order with fields unchanged.
- Reset mid-ACTIVE: rst_i pulsed -> ev_valid_o=0, both counters 0; the next T1_i starts a clean event with len=1.

Source files
------------

// File: rtl/t1_event_builder.sv
// t1_event_builder: turns each T1 burst into one readout event record and queues it
// in a small first-word-fall-through FIFO for the IRS readout controller.
module t1_event_builder #(
    parameter int NUM_L4          = 4,
    parameter int BLOCK_BITS      = 9,
    parameter int LEN_BITS        = 8,
    parameter int MAX_LEN         = 255,
    parameter int POST_BLOCKS     = 4,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  T1_i,
    input  logic [8:0]            T1_offset_i,
    input  logic [NUM_L4-1:0]     l4_i,
    input  logic [NUM_L4-1:0]     l4_new_i,
    input  logic [BLOCK_BITS-1:0] wr_block_i,
    input  logic                  block_ce_i,
    output logic                  ev_valid_o,
    input  logic                  ev_ready_i,
    output logic [BLOCK_BITS-1:0] ev_start_o,
    output logic [LEN_BITS-1:0]   ev_len_o,
    output logic [NUM_L4-1:0]     ev_pattern_o,
    output logic [NUM_L4-1:0]     ev_new_o,
    output logic                  ev_trunc_o,
    output logic                  fifo_full_o,
    output logic [15:0]           event_count_o,
    output logic [15:0]           drop_count_o
);
    localparam int PW    = FIFO_DEPTH_LOG2;
    localparam int DEPTH = 1 << PW;

    typedef enum logic [1:0] {IDLE, ACTIVE, POST, PUSH} state_t;
    typedef struct packed {
        logic [BLOCK_BITS-1:0] start;
        logic [LEN_BITS-1:0]   len;
        logic [NUM_L4-1:0]     pat;
        logic [NUM_L4-1:0]     nw;
        logic                  trunc;
    } rec_t;

    state_t              state_q, state_d;
    rec_t                rec_q, rec_d;
    logic [LEN_BITS-1:0] post_q, post_d;
    rec_t                mem_q [DEPTH];
    rec_t                mem_d [DEPTH];
    logic [PW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW:0]         cnt_q, cnt_d;
    logic                full_q, full_d;
    logic [15:0]         ev_cnt_q, ev_cnt_d, drop_cnt_q, drop_cnt_d;
    logic                start_ev, pop, wr_en;

    always_comb begin
        state_d  = state_q;
        rec_d    = rec_q;
        post_d   = post_q;
        start_ev = 1'b0;
        case (state_q)
            IDLE: start_ev = T1_i;
            ACTIVE: begin
                if (T1_i) begin
                    rec_d.pat = rec_q.pat | l4_i;
                    rec_d.nw  = rec_q.nw | l4_new_i;
                end else begin
                    post_d  = LEN_BITS'(POST_BLOCKS);
                    state_d = (POST_BLOCKS == 0) ? PUSH : POST;
                end
                if (block_ce_i) rec_d.len = rec_q.len + LEN_BITS'(1);
            end
            POST: begin
                if (T1_i) begin
                    rec_d.pat = rec_q.pat | l4_i;
                    rec_d.nw  = rec_q.nw | l4_new_i;
                    state_d   = ACTIVE;
                end else if (block_ce_i) begin
                    rec_d.len = rec_q.len + LEN_BITS'(1);
                    post_d    = post_q - LEN_BITS'(1);
                    if (post_d == '0) state_d = PUSH;
                end
            end
            PUSH: begin
                start_ev = T1_i;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // hitting MAX_LEN closes the event regardless of T1 or a pending post window
        if ((state_q == ACTIVE || state_q == POST) && rec_d.len == LEN_BITS'(MAX_LEN)) begin
            rec_d.trunc = 1'b1;
            state_d     = PUSH;
        end
        if (start_ev) begin
            rec_d.start = wr_block_i - T1_offset_i[BLOCK_BITS-1:0];
            rec_d.len   = LEN_BITS'(1);
            rec_d.pat   = l4_i;
            rec_d.nw    = l4_new_i;
            rec_d.trunc = 1'b0;
            state_d     = ACTIVE;
        end
    end

    // a pop in the same cycle frees a slot, so a push into a full FIFO still lands
    assign pop   = ev_valid_o && ev_ready_i;
    assign wr_en = (state_q == PUSH) && (!full_q || pop);

    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[wptr_q] = rec_q;
        wptr_d     = wptr_q + PW'(wr_en);
        rptr_d     = rptr_q + PW'(pop);
        cnt_d      = cnt_q + (PW+1)'(wr_en) - (PW+1)'(pop);
        full_d     = cnt_d == (PW+1)'(DEPTH);
        ev_cnt_d   = ev_cnt_q + 16'(wr_en);
        drop_cnt_d = drop_cnt_q + 16'((state_q == PUSH) && !wr_en && drop_cnt_q != 16'hFFFF);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            rec_q      <= '0;
            post_q     <= '0;
            mem_q      <= '{default: '0};
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            full_q     <= 1'b0;
            ev_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rec_q      <= rec_d;
            post_q     <= post_d;
            mem_q      <= mem_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            full_q     <= full_d;
            ev_cnt_q   <= ev_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign ev_valid_o    = cnt_q != '0;
    assign {ev_start_o, ev_len_o, ev_pattern_o, ev_new_o, ev_trunc_o} = mem_q[rptr_q];
    assign fifo_full_o   = full_q;
    assign event_count_o = ev_cnt_q;
    assign drop_count_o  = drop_cnt_q;
endmodule

// File: tb/tb_t1_event_builder.sv
// tb_t1_event_builder: scenario tasks drive T1 bursts; expected records are queued
// as stimulus is applied and compared against records popped from the DUT.
module tb_t1_event_builder;
    logic        clk = 1'b0, rst = 1'b1;
    logic        t1 = 1'b0, ce = 1'b0, ev_ready = 1'b0;
    logic [8:0]  off = '0, wr = '0;
    logic [3:0]  l4 = '0, nw = '0;
    logic        ev_valid, ev_trunc, fifo_full;
    logic [8:0]  ev_start;
    logic [7:0]  ev_len;
    logic [3:0]  ev_pat, ev_new;
    logic [15:0] ev_cnt, drop_cnt;
    logic [25:0] exp_q[$];
    logic [25:0] got_q[$];
    int          got_rd = 0, vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    t1_event_builder dut (
        .clk_i(clk), .rst_i(rst), .T1_i(t1), .T1_offset_i(off), .l4_i(l4), .l4_new_i(nw),
        .wr_block_i(wr), .block_ce_i(ce), .ev_valid_o(ev_valid), .ev_ready_i(ev_ready),
        .ev_start_o(ev_start), .ev_len_o(ev_len), .ev_pattern_o(ev_pat), .ev_new_o(ev_new),
        .ev_trunc_o(ev_trunc), .fifo_full_o(fifo_full), .event_count_o(ev_cnt),
        .drop_count_o(drop_cnt)
    );

    // capture every record the readout side actually accepts
    always @(negedge clk) if (ev_valid && ev_ready) got_q.push_back({ev_start, ev_len, ev_pat, ev_new, ev_trunc});

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic t, input logic c, input logic [3:0] l, input logic [3:0] n);
        t1 = t; ce = c; l4 = l; nw = n;
        tick();
    endtask

    // drop T1, deliver four post blocks, then spend the PUSH cycle
    task automatic post4();
        drive(0, 0, 0, 0);
        repeat (4) drive(0, 1, 0, 0);
        drive(0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({ev_valid, fifo_full, ev_trunc} !== 3'b000) begin
            miscompares++; $display("FAIL reset_flags got %b want 000", {ev_valid, fifo_full, ev_trunc});
        end
        vectors++;
        if ({ev_start, ev_len, ev_pat, ev_new} !== 25'd0) begin
            miscompares++; $display("FAIL reset_head got %h want 0", {ev_start, ev_len, ev_pat, ev_new});
        end
        vectors++;
        if ({ev_cnt, drop_cnt} !== 32'd0) begin
            miscompares++; $display("FAIL reset_counts got %h want 0", {ev_cnt, drop_cnt});
        end
        tick();
        rst = 1'b0;
        ev_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        vectors++;
        if ({ev_valid, fifo_full} !== 2'b00) begin
            miscompares++; $display("FAIL ready_when_empty got %b want 00", {ev_valid, fifo_full});
        end
        tick();
        ev_ready = 1'b0;
    endtask

    task automatic test_single();
        logic [25:0] e, g;
        wr = 9'd100; off = 9'd6;
        drive(1, 0, 4'b0010, 4'b0000);
        drive(1, 1, 4'b0100, 4'b0001);
        drive(1, 0, 4'b0100, 4'b0000);
        drive(0, 0, 0, 0);
        repeat (4) drive(0, 1, 0, 0);
        ce = 1'b0;
        exp_q.push_back({9'd94, 8'd6, 4'b0110, 4'b0001, 1'b0});
        @(negedge clk);
        vectors++;
        if (ev_valid !== 1'b0) begin
            miscompares++; $display("FAIL single_valid_in_push got %b want 0", ev_valid);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (ev_valid !== 1'b1) begin
            miscompares++; $display("FAIL single_valid_after_push got %b want 1", ev_valid);
        end
        tick();
        ev_ready = 1'b1;
        for (int c = 0; c < 50 && got_q.size() < got_rd + exp_q.size(); c++) @(negedge clk);
        tick();
        ev_ready = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_rd < got_q.size()) ? got_q[got_rd] : 26'bx;
            got_rd++; vectors++;
            if (g !== e) begin miscompares++; $display("FAIL single_rec got %h want %h", g, e); end
        end
        @(negedge clk);
        vectors++;
        if ({ev_cnt, drop_cnt} !== {16'd1, 16'd0}) begin
            miscompares++; $display("FAIL single_counts got %h want 00010000", {ev_cnt, drop_cnt});
        end
    endtask

    task automatic test_wrap();
        logic [25:0] e, g;
        tick();
        wr = 9'd2; off = 9'd5;
        drive(1, 0, 4'b1000, 4'b0000);
        post4();
        exp_q.push_back({9'd509, 8'd5, 4'b1000, 4'b0000, 1'b0});
        ev_ready = 1'b1;
        for (int c = 0; c < 50 && got_q.size() < got_rd + exp_q.size(); c++) @(negedge clk);
        tick();
        ev_ready = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_rd < got_q.size()) ? got_q[got_rd] : 26'bx;
            got_rd++; vectors++;
            if (g !== e) begin miscompares++; $display("FAIL wrap_rec got %h want %h", g, e); end
        end
        @(negedge clk);
        vectors++;
        if (ev_cnt !== 16'd2) begin miscompares++; $display("FAIL wrap_count got %0d want 2", ev_cnt); end
    endtask

    task automatic test_retrigger();
        logic [25:0] e, g;
        tick();
        wr = 9'd50; off = 9'd0;
        drive(1, 0, 4'b0001, 4'b0000);
        drive(1, 1, 4'b0000, 4'b0000);
        drive(0, 0, 0, 0);
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        wr = 9'd60;
        drive(1, 0, 4'b0010, 4'b0100);
        drive(1, 1, 4'b0000, 4'b0000);
        post4();
        exp_q.push_back({9'd50, 8'd9, 4'b0011, 4'b0100, 1'b0});
        ev_ready = 1'b1;
        for (int c = 0; c < 50 && got_q.size() < got_rd + exp_q.size(); c++) @(negedge clk);
        tick();
        ev_ready = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_rd < got_q.size()) ? got_q[got_rd] : 26'bx;
            got_rd++; vectors++;
            if (g !== e) begin miscompares++; $display("FAIL retrig_rec got %h want %h", g, e); end
        end
        @(negedge clk);
        vectors++;
        if (ev_cnt !== 16'd3) begin miscompares++; $display("FAIL retrig_count got %0d want 3", ev_cnt); end
    endtask

    task automatic test_trunc();
        logic [25:0] e, g;
        tick();
        wr = 9'd10; off = 9'd0;
        drive(1, 0, 4'b0001, 4'b0000);
        repeat (300) drive(1, 1, 4'b0100, 4'b0000);
        post4();
        exp_q.push_back({9'd10, 8'd255, 4'b0101, 4'b0000, 1'b1});
        exp_q.push_back({9'd10, 8'd50, 4'b0100, 4'b0000, 1'b0});
        @(negedge clk);
        vectors++;
        if ({ev_valid, ev_trunc, ev_len} !== {1'b1, 1'b1, 8'd255}) begin
            miscompares++; $display("FAIL trunc_head got %h want 3ff", {ev_valid, ev_trunc, ev_len});
        end
        tick();
        ev_ready = 1'b1;
        for (int c = 0; c < 50 && got_q.size() < got_rd + exp_q.size(); c++) @(negedge clk);
        tick();
        ev_ready = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_rd < got_q.size()) ? got_q[got_rd] : 26'bx;
            got_rd++; vectors++;
            if (g !== e) begin miscompares++; $display("FAIL trunc_rec got %h want %h", g, e); end
        end
        @(negedge clk);
        vectors++;
        if (ev_cnt !== 16'd5) begin miscompares++; $display("FAIL trunc_count got %0d want 5", ev_cnt); end
    endtask

    task automatic test_backpressure();
        logic [25:0] e, g;
        tick();
        off = 9'd1;
        for (int k = 1; k <= 6; k++) begin
            wr = 9'(k * 20);
            drive(1, 0, 4'(k), 4'b0000);
            post4();
            if (k <= 4) exp_q.push_back({9'(k * 20 - 1), 8'd5, 4'(k), 4'b0000, 1'b0});
        end
        @(negedge clk);
        vectors++;
        if ({fifo_full, ev_valid} !== 2'b11) begin
            miscompares++; $display("FAIL bp_full got %b want 11", {fifo_full, ev_valid});
        end
        vectors++;
        if ({ev_cnt, drop_cnt} !== {16'd9, 16'd2}) begin
            miscompares++; $display("FAIL bp_counts got %h want 00090002", {ev_cnt, drop_cnt});
        end
        repeat (3) tick();
        @(negedge clk);
        vectors++;
        if ({ev_start, ev_len, ev_pat} !== {9'd19, 8'd5, 4'd1}) begin
            miscompares++; $display("FAIL bp_head_stable got %h want %h", {ev_start, ev_len, ev_pat}, {9'd19, 8'd5, 4'd1});
        end
        tick();
        ev_ready = 1'b1;
        for (int c = 0; c < 50 && got_q.size() < got_rd + exp_q.size(); c++) @(negedge clk);
        tick();
        ev_ready = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_rd < got_q.size()) ? got_q[got_rd] : 26'bx;
            got_rd++; vectors++;
            if (g !== e) begin miscompares++; $display("FAIL bp_rec got %h want %h", g, e); end
        end
        @(negedge clk);
        vectors++;
        if ({fifo_full, ev_valid} !== 2'b00) begin
            miscompares++; $display("FAIL bp_drained got %b want 00", {fifo_full, ev_valid});
        end
    endtask

    task automatic test_reset_mid();
        logic [25:0] e, g;
        tick();
        wr = 9'd30; off = 9'd0;
        drive(1, 0, 4'b0001, 4'b0000);
        post4();
        drive(1, 0, 4'b0001, 4'b0000);
        drive(1, 1, 4'b0000, 4'b0000);
        @(negedge clk);
        vectors++;
        if ({ev_valid, ev_cnt} !== {1'b1, 16'd10}) begin
            miscompares++; $display("FAIL pre_reset got %h want 1000a", {ev_valid, ev_cnt});
        end
        tick();
        rst = 1'b1; t1 = 1'b0; ce = 1'b0;
        @(negedge clk);
        vectors++;
        if ({ev_valid, fifo_full, ev_cnt, drop_cnt} !== 34'd0) begin
            miscompares++; $display("FAIL mid_reset got %h want 0", {ev_valid, fifo_full, ev_cnt, drop_cnt});
        end
        tick();
        rst = 1'b0;
        wr = 9'd7;
        drive(1, 0, 4'b0010, 4'b0000);
        post4();
        exp_q.push_back({9'd7, 8'd5, 4'b0010, 4'b0000, 1'b0});
        ev_ready = 1'b1;
        for (int c = 0; c < 50 && got_q.size() < got_rd + exp_q.size(); c++) @(negedge clk);
        tick();
        ev_ready = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_rd < got_q.size()) ? got_q[got_rd] : 26'bx;
            got_rd++; vectors++;
            if (g !== e) begin miscompares++; $display("FAIL post_reset_rec got %h want %h", g, e); end
        end
        @(negedge clk);
        vectors++;
        if (ev_cnt !== 16'd1) begin miscompares++; $display("FAIL post_reset_count got %0d want 1", ev_cnt); end
        vectors++;
        if (got_q.size() !== got_rd) begin
            miscompares++; $display("FAIL extra_records got %0d want %0d", got_q.size(), got_rd);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_retrigger();
        test_trunc();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
